pll_reset_sequencer: RTL
========================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port `clock` on the rising edge, and port `reset` synchronous to `clock`.
REQ-002 Parameter SYNC_STAGES SHALL default to 2 and set the number of synchronizer flops on pll_locked; the legal range is 2 or more.
REQ-003 Parameter LOCK_FILTER SHALL default to 16 and set the number of consecutive synchronized-locked cycles required; the legal range is 1 or more.
REQ-004 Parameter HOLD_CYCLES SHALL default to 1024 and set how many cycles rst_out stays asserted after the filter passes; the legal range is 1 or more.
REQ-005 Port `clock` SHALL be an input, 1 bit wide: the PLL output clock of the destination domain.
REQ-006 Port `reset` SHALL be an input, 1 bit wide: the external sequencer reset, synchronous and active-high.
REQ-007 Port `pll_locked` SHALL be an input, 1 bit wide: the PLL lock indicator, asynchronous to `clock`.
REQ-008 Port `rst_out` SHALL be an output, 1 bit wide: the registered, active-high reset for downstream logic in the `clock` domain.
REQ-009 Port `ready` SHALL be an output, 1 bit wide: high only in state RUN; it is always the inverse of rst_out.
REQ-010 Port `state_o` SHALL be an output, 2 bits wide: the current FSM state, for debug.
REQ-011 Port `lock_loss_count` SHALL be an output, 8 bits wide: the saturating count of lock losses that occurred while in RUN.

Function
REQ-012 pll_locked SHALL pass through SYNC_STAGES flops before any use; the synchronized signal is lk_s.
REQ-013 The FSM SHALL have four states: WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3.
REQ-014 In WAIT_LOCK, lk_s=1 SHALL cause a move to FILTER and clear cnt.
REQ-015 In FILTER, lk_s=0 SHALL cause a return to WAIT_LOCK; otherwise cnt increments, and when cnt=LOCK_FILTER-1 the FSM moves to HOLD and clears cnt.
REQ-016 In HOLD, lk_s=0 SHALL cause a return to WAIT_LOCK, which is not counted as a loss; when cnt=HOLD_CYCLES-1 the FSM moves to RUN.
REQ-017 In RUN, lk_s=0 SHALL cause a move to WAIT_LOCK and increment lock_loss_count.
REQ-018 rst_out and ready SHALL be registered and decoded from the next state, so they change on the same edge as state_o.
REQ-019 From the first cycle lk_s=1 in WAIT_LOCK, rst_out SHALL deassert exactly 1+LOCK_FILTER+HOLD_CYCLES edges later, provided lk_s stays 1.
REQ-020 From lk_s falling in RUN, rst_out SHALL be 1 after the next edge (one-cycle latency).
REQ-021 lock_loss_count SHALL saturate at 255 and never wrap.
REQ-022 cnt SHALL be $clog2(max(LOCK_FILTER,HOLD_CYCLES)+1) bits wide and SHALL never overflow.
REQ-023 A glitch of any length on lk_s during FILTER or HOLD SHALL restart the full sequence from WAIT_LOCK.

Reset
REQ-024 On reset=1, the FSM SHALL go to WAIT_LOCK on the next edge.
REQ-025 On reset=1, cnt, lock_loss_count and all synchronizer flops SHALL be set to 0.
REQ-026 On reset=1, rst_out SHALL be set to 1, ready to 0 and state_o to 0.
REQ-027 reset asserted in any state, including mid-HOLD or RUN, SHALL take priority over all transitions.
REQ-028 rst_out SHALL be 1 from the first edge after configuration; the power-up initial value is rst_out=1.

Configuration
REQ-029 The macro PLL_RST_LOSS_COUNT_EN SHALL control the lock-loss counter.
REQ-030 With PLL_RST_LOSS_COUNT_EN defined, the lock-loss counter SHALL be built and behave as in REQ-017 and REQ-021.
REQ-031 With PLL_RST_LOSS_COUNT_EN undefined, no counter register SHALL exist and lock_loss_count SHALL be tied to 8'd0; all other behaviour is identical.

Structure
REQ-032 The package pll_rst_pkg SHALL hold the state encoding constants (ST_WAIT_LOCK, ST_FILTER, ST_HOLD, ST_RUN) and the lock_loss_count width constant (8).
REQ-033 The sub-module sync_ff (parameter STAGES) SHALL implement the synchronizer, with reset values of 0.
REQ-034 The FSM and counters SHALL reside in pll_reset_sequencer.

Verification (LOCK_FILTER=4, HOLD_CYCLES=8, SYNC_STAGES=2)
REQ-035 Clean lock: with pll_locked rising at edge 0 and then held, rst_out SHALL fall and ready SHALL rise at edge 15; state_o SHALL step 0,1,2,3.
REQ-036 Filter glitch: pll_locked low for 1 cycle at edge 5 SHALL return the FSM to WAIT_LOCK; rst_out SHALL stay 1 and the full 15-edge sequence SHALL restart after relock; lock_loss_count SHALL be 0.
REQ-037 Loss in RUN: dropping pll_locked while in RUN SHALL make rst_out=1 within 3 edges (SYNC_STAGES+1) and lock_loss_count=1; relocking SHALL produce another 15-edge sequence.
REQ-038 Saturation: 300 lock/loss cycles through RUN SHALL leave lock_loss_count=255 (0 when PLL_RST_LOSS_COUNT_EN is undefined).
REQ-039 Reset mid-HOLD: reset=1 for 1 cycle at edge 10 SHALL make state_o=0 and rst_out=1 on the next edge with lock_loss_count=0; with pll_locked held high, RUN SHALL be reached 2+1+4+8 edges after reset is released.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared constants for the PLL reset sequencer: FSM state encoding,
// lock-loss counter width and a small elaboration-time helper.
package pll_rst_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_FILTER    = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam int LOSS_W = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level into the clock
// domain. All stages clear to 0 on the synchronous reset so a fresh lock
// must propagate through the full chain after reset is released.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clock) begin
      if (reset) begin
         sr <= '0;
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronizes pll_locked, requires LOCK_FILTER
// consecutive locked cycles, holds rst_out for HOLD_CYCLES more, then
// releases downstream reset. Any loss of lock before or during RUN
// restarts the sequence from WAIT_LOCK.
//
// Optional feature macro: PLL_RST_LOSS_COUNT_EN builds the saturating
// lock-loss counter; without it lock_loss_count is tied to zero.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_WAIT_LOCK | waiting for synchronized lock, rst_out asserted
//   ST_FILTER    | counting consecutive locked cycles, rst_out asserted
//   ST_HOLD      | lock qualified, holding rst_out for HOLD_CYCLES
//   ST_RUN       | reset released, ready high
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILTER = 16,
   parameter int HOLD_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pll_locked,
   output logic              rst_out,
   output logic              ready,
   output logic [1:0]        state_o,
   output logic [LOSS_W-1:0] lock_loss_count
);

   // One counter is shared between FILTER and HOLD; it is sized for the
   // larger terminal value so neither phase can overflow it.
   localparam int CNT_W = $clog2(max_int(LOCK_FILTER, HOLD_CYCLES) + 1);
   localparam logic [CNT_W-1:0] LF_TC = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] HC_TC = CNT_W'(HOLD_CYCLES - 1);

   logic             lk_s;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             rst_nxt;
   // Power-up value keeps downstream logic in reset before the first edge.
   logic             rst_q = 1'b1;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (pll_locked),
      .q     (lk_s)
   );

   // Next-state, counter and reset-output decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_WAIT_LOCK: begin
            if (lk_s) begin
               state_nxt = ST_FILTER;
               cnt_nxt   = '0;
            end
         end
         ST_FILTER: begin
            if (!lk_s) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == LF_TC) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            // A drop here is a failed qualification, not a lock loss.
            if (!lk_s) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == HC_TC) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            cnt_nxt = '0;
            if (!lk_s) begin
               state_nxt = ST_WAIT_LOCK;
            end
         end
         default: begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
         end
      endcase
      // Decoding from the next state lines rst_out up with state_o.
      rst_nxt = (state_nxt != ST_RUN);
   end

   // State, counter and registered reset output.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_WAIT_LOCK;
         cnt   <= '0;
         rst_q <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rst_q <= rst_nxt;
      end
   end

   assign rst_out = rst_q;
   assign ready   = ~rst_q;
   assign state_o = state;

`ifdef PLL_RST_LOSS_COUNT_EN
   logic [LOSS_W-1:0] loss_q;
   logic              loss_evt;

   assign loss_evt = (state == ST_RUN) && !lk_s;

   // Saturating count of lock losses seen while running.
   always_ff @(posedge clock) begin
      if (reset) begin
         loss_q <= '0;
      end else if (loss_evt && (loss_q != {LOSS_W{1'b1}})) begin
         loss_q <= loss_q + LOSS_W'(1);
      end
   end

   assign lock_loss_count = loss_q;
`else
   assign lock_loss_count = '0;
`endif

endmodule
